// File: rtl/mem_arbiter_rr_if.sv
// Bundle between the cache-side requesters, the arbiter and the shared next-level memory port.
// Latency: none, wires only; timing is set by the arbiter that owns the slave view.
// Backpressure: requesters hold req_read/req_write until their req_resp pulse arrives.

interface mem_arbiter_rr_if #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
);
   // Requester side, one lane per port, port i at [i*WIDTH +: WIDTH]
   logic [NUM_PORTS-1:0]            req_read;
   logic [NUM_PORTS-1:0]            req_write;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
   logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
   logic [NUM_PORTS-1:0]            req_resp;
   logic [LINE_WIDTH-1:0]           req_rdata;

   // Shared downstream side
   logic                            mem_read;
   logic                            mem_write;
   logic [ADDR_WIDTH-1:0]           mem_address;
   logic [LINE_WIDTH-1:0]           mem_wdata;
   logic                            mem_resp;
   logic [LINE_WIDTH-1:0]           mem_rdata;

   // Current owner, one-hot, zero when idle
   logic [NUM_PORTS-1:0]            grant;

   // Arbiter view
   modport slave (
      input  req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
      output req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata, grant
   );

   // Environment view: requesters plus the downstream memory
   modport master (
      output req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
      input  req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata, grant
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Shares one next-level memory port among NUM_PORTS cache miss/writeback ports, one transaction in flight.
// Latency: request in cycle t -> downstream strobe in t+1; req_resp is combinational with mem_resp.
// Backpressure: requesters hold their request until req_resp; a DONE cycle follows every completion.

module mem_arbiter_rr #(
   parameter int NUM_PORTS     = 2,
   parameter int ADDR_WIDTH    = 16,
   parameter int LINE_WIDTH    = 128,
   parameter int PRIORITY_MODE = 0     // 0 = round-robin, 1 = fixed (lowest index wins)
) (
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_rr_if.slave bus
);

   localparam int               IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Elaboration-time guard on the supported configuration range
   if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
      $error("mem_arbiter_rr: NUM_PORTS must be in 2..8");
   end
   if (PRIORITY_MODE != 0 && PRIORITY_MODE != 1) begin : g_bad_mode
      $error("mem_arbiter_rr: PRIORITY_MODE must be 0 or 1");
   end

   state_t                 state_q,    state_d;
   logic [NUM_PORTS-1:0]   grant_q,    grant_d;
   logic [IDX_W-1:0]       owner_q,    owner_d;
   logic [IDX_W-1:0]       ptr_q,      ptr_d;
   logic                   op_write_q, op_write_d;
   logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
   logic [LINE_WIDTH-1:0]  wdata_q,    wdata_d;

   logic [NUM_PORTS-1:0]   active;
   logic                   win_vld;
   logic [IDX_W-1:0]       win_idx;
   logic                   win_write;
   logic [ADDR_WIDTH-1:0]  win_addr;
   logic [LINE_WIDTH-1:0]  win_wdata;

   logic                   rd_strobe;
   logic                   wr_strobe;
   logic [NUM_PORTS-1:0]   resp_vec;

   assign active = bus.req_read | bus.req_write;

   // Winner search: candidates are visited from farthest to nearest so the last hit is the winner.
   // Round-robin starts at the pointer and wraps; fixed mode starts at port 0.
   always_comb begin
      int cand;
      cand      = 0;
      win_vld   = 1'b0;
      win_idx   = '0;
      win_write = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (PRIORITY_MODE == 1) begin
            cand = k;
         end else begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_PORTS) begin
               cand = cand - NUM_PORTS;
            end
         end
         if (active[cand]) begin
            win_vld   = 1'b1;
            win_idx   = IDX_W'(cand);
            // Read and write together is treated as a write
            win_write = bus.req_write[cand];
            win_addr  = bus.req_address[cand*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = bus.req_wdata[cand*LINE_WIDTH +: LINE_WIDTH];
         end
      end
   end

   // FSM next state and outputs: latch the winner in IDLE, strobe in BUSY, release grant after DONE
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      op_write_d = op_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_strobe  = 1'b0;
      wr_strobe  = 1'b0;
      resp_vec   = '0;

      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d    = BUSY;
               grant_d    = NUM_PORTS'(1) << win_idx;
               owner_d    = win_idx;
               op_write_d = win_write;
               addr_d     = win_addr;
               wdata_d    = win_wdata;
            end
         end
         BUSY: begin
            rd_strobe = ~op_write_q;
            wr_strobe = op_write_q;
            // Completion goes only to the owner, in the same cycle as mem_resp
            if (bus.mem_resp) begin
               resp_vec = grant_q;
               state_d  = DONE;
            end
         end
         DONE: begin
            // Grant stays up this cycle so the owner can drop its request before rearbitration
            state_d = IDLE;
            grant_d = '0;
            if (owner_q == LAST_IDX) begin
               ptr_d = '0;
            end else begin
               ptr_d = owner_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers; reset also abandons any in-flight downstream transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         ptr_q      <= '0;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         op_write_q <= op_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign bus.mem_read    = rd_strobe;
   assign bus.mem_write   = wr_strobe;
   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.req_resp    = resp_vec;
   assign bus.req_rdata   = bus.mem_rdata;   // shared by all ports, meaningful only with req_resp
   assign bus.grant       = grant_q;

endmodule
